// File: rtl/uart_pkg.sv
// Shared constants and width helpers for the UART receive byte packer.
package uart_pkg;

  localparam int UART_DATA_WIDTH     = 8;
  localparam int UART_BYTES_PER_WORD = 4;
  localparam int UART_FIFO_DEPTH     = 8;
  localparam int UART_TIMEOUT_CLKS   = 4096;

  // Width of one packed output word.
  function automatic int word_width(input int data_width, input int bytes_per_word);
    return data_width * bytes_per_word;
  endfunction

  // Width of an occupancy counter that must be able to hold the value depth itself.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_rx_packer_sync_fifo.sv
// First-word fall-through synchronous FIFO (module sync_fifo).
// Pointers carry an extra wrap bit so full and empty are told apart by subtraction.
// The head word is held in a register that is refreshed whenever the next head changes,
// so dout keeps its last value once the FIFO runs empty.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic                          pop,
  input  logic [WIDTH-1:0]              din,
  output logic [WIDTH-1:0]              dout,
  output logic [count_width(DEPTH)-1:0] count,
  output logic                          full,
  output logic                          empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = count_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic [AW:0]      wr_ptr_next;
  logic [AW:0]      rd_ptr_next;
  logic             push_ok;
  logic             pop_ok;

  assign count   = CW'(wr_ptr_reg - rd_ptr_reg);
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // A push into a full FIFO is only taken when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;

  // Pointer advance for this cycle.
  always_comb begin
    wr_ptr_next = wr_ptr_reg + (AW+1)'(push_ok);
    rd_ptr_next = rd_ptr_reg + (AW+1)'(pop_ok);
  end

  // Storage array; no reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg[AW-1:0]] <= din;
    end
  end

  // Read and write pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
    end
  end

  // Registered head word; bypasses din when the incoming word becomes the new head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout <= '0;
    end else if (wr_ptr_next != rd_ptr_next) begin
      if (push_ok && (wr_ptr_reg == rd_ptr_next)) begin
        dout <= din;
      end else begin
        dout <= mem[rd_ptr_next[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/uart_rx_packer.sv
// Packs received UART bytes little-endian into bus words and queues them in a FIFO.
// Optional partial-word timeout flush is built when UART_PACKER_TIMEOUT_EN is defined;
// otherwise timeout_err is tied low and a partial word waits indefinitely.
module uart_rx_packer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = UART_DATA_WIDTH,
  parameter int BYTES_PER_WORD = UART_BYTES_PER_WORD,
  parameter int FIFO_DEPTH     = UART_FIFO_DEPTH,
  parameter int TIMEOUT_CLKS   = UART_TIMEOUT_CLKS
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  rx_valid,
  input  logic [DATA_WIDTH-1:0]                 rx_data,
  output logic                                  m_valid,
  input  logic                                  m_ready,
  output logic [DATA_WIDTH*BYTES_PER_WORD-1:0]  m_data,
  output logic [$clog2(FIFO_DEPTH):0]           fifo_count,
  output logic                                  overflow,
  input  logic                                  clear_err,
  output logic                                  timeout_err
);

  localparam int WORD_W = word_width(DATA_WIDTH, BYTES_PER_WORD);
  localparam int IDX_W  = $clog2(BYTES_PER_WORD);

  if (BYTES_PER_WORD < 2 || TIMEOUT_CLKS < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
    $error("uart_rx_packer: illegal parameter combination");
  end

  logic                rx_valid_d;
  logic                byte_accept;
  logic                last_byte;
  logic                word_push;
  logic                word_drop;
  logic [IDX_W-1:0]    idx_reg;
  logic [WORD_W-1:0]   word_assembled;
  logic                fifo_full;
  logic                fifo_empty;
  logic                timeout_hit;

  assign byte_accept = rx_valid && !rx_valid_d;
  assign last_byte   = (idx_reg == IDX_W'(BYTES_PER_WORD - 1));
  assign word_push   = byte_accept && last_byte;
  // A completed word is lost only when the FIFO is full and nothing leaves this cycle.
  assign word_drop   = word_push && fifo_full && !m_ready;

  // Rising-edge detector; starts high so a level already present at reset release is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_valid_d <= 1'b1;
    end else begin
      rx_valid_d <= rx_valid;
    end
  end

  // One lane register per byte position; the current byte is forwarded so the
  // completing byte is part of the word pushed in the same cycle.
  for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
    logic                  lane_hit;
    logic [DATA_WIDTH-1:0] lane_reg;

    assign lane_hit = byte_accept && (idx_reg == IDX_W'(gi));
    assign word_assembled[gi*DATA_WIDTH +: DATA_WIDTH] = lane_hit ? rx_data : lane_reg;

    // Capture the accepted byte into its lane.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        lane_reg <= '0;
      end else if (lane_hit) begin
        lane_reg <= rx_data;
      end
    end
  end

  // Byte index: advances per accepted byte, wraps after the last lane or on a timeout flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_reg <= '0;
    end else if (byte_accept) begin
      idx_reg <= last_byte ? '0 : idx_reg + IDX_W'(1);
    end else if (timeout_hit) begin
      idx_reg <= '0;
    end
  end

  // Sticky overflow flag; clear_err wins over a simultaneous drop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (clear_err) begin
      overflow <= 1'b0;
    end else if (word_drop) begin
      overflow <= 1'b1;
    end
  end

`ifdef UART_PACKER_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CLKS);

  logic [IDLE_W-1:0] idle_cnt_reg;
  logic              timeout_err_reg;

  assign timeout_hit = (idx_reg != '0) && !byte_accept &&
                       (idle_cnt_reg == IDLE_W'(TIMEOUT_CLKS - 1));
  assign timeout_err = timeout_err_reg;

  // Idle counter: runs only while a partial word is pending, restarts on every byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt_reg <= '0;
    end else if (byte_accept || (idx_reg == '0) || timeout_hit) begin
      idle_cnt_reg <= '0;
    end else begin
      idle_cnt_reg <= idle_cnt_reg + IDLE_W'(1);
    end
  end

  // Sticky timeout flag; clear_err wins over a simultaneous flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_err_reg <= 1'b0;
    end else if (clear_err) begin
      timeout_err_reg <= 1'b0;
    end else if (timeout_hit) begin
      timeout_err_reg <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (word_push),
    .pop   (m_ready),
    .din   (word_assembled),
    .dout  (m_data),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign m_valid = !fifo_empty;

endmodule

// File: tb/tb_uart_rx_packer.sv
// Directed bench for uart_rx_packer with an expected-word scoreboard.
// Timeout scenario checks follow UART_PACKER_TIMEOUT_EN.
module tb_uart_rx_packer;

  logic        clk;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic [3:0]  fifo_count;
  logic        overflow;
  logic        clear_err;
  logic        timeout_err;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];

  uart_rx_packer dut (
    .clk         (clk),
    .rst         (rst),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .fifo_count  (fifo_count),
    .overflow    (overflow),
    .clear_err   (clear_err),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every word the consumer actually takes.
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) got_q.push_back(m_data);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-18s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One-cycle rx_valid pulse carrying byte b.
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit expect_it);
    for (int i = 0; i < 4; i++) send_byte(w[i*8 +: 8]);
    if (expect_it) exp_q.push_back(w);
  endtask

  // Drain the FIFO and compare everything taken against the scoreboard.
  task automatic drain(input string tag);
    bit done;
    done = 1'b0;
    @(posedge clk); #1;
    m_ready = 1'b1;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (fifo_count == 4'd0) done = 1'b1;
    end
    m_ready = 1'b0;
    check({tag, "_drained"}, 32'(done), 32'd1);
    check({tag, "_nwords"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      check({tag, "_word"}, got_q.pop_front(), exp_q.pop_front());
    end
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    rst       = 1'b1;
    rx_valid  = 1'b1;   // level already high at reset release must not count
    rx_data   = 8'h55;
    m_ready   = 1'b0;
    clear_err = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_m_data", m_data, 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_timeout", 32'(timeout_err), 32'd0);
    repeat (3) @(posedge clk);
    #1 rx_valid = 1'b0;

    // Basic word and first-word fall-through latency.
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_data  = 8'h44;
    @(negedge clk);
    check("lat_before", 32'(m_valid), 32'd0);
    @(posedge clk); #1;
    rx_valid = 1'b0;
    exp_q.push_back(32'h44332211);
    check("lat_m_valid", 32'(m_valid), 32'd1);
    check("lat_count", 32'(fifo_count), 32'd1);
    check("lat_m_data", m_data, 32'h44332211);
    drain("basic");
    check("empty_m_valid", 32'(m_valid), 32'd0);
    check("empty_hold", m_data, 32'h44332211);

    // Long rx_valid level: only one byte taken.
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_data  = 8'hAA;
    repeat (50) @(posedge clk);
    #1 rx_valid = 1'b0;
    check("level_no_word", 32'(fifo_count), 32'd0);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    exp_q.push_back(32'h030201AA);
    drain("level");

    // Overflow: nine words into eight entries, consumer stalled.
    for (int k = 0; k < 9; k++) begin
      send_word({8'h40 + 8'(k), 8'h30 + 8'(k), 8'h20 + 8'(k), 8'h10 + 8'(k)}, k < 8);
    end
    check("ovf_count", 32'(fifo_count), 32'd8);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_head_steady", m_data, 32'h40302010);
    @(posedge clk); #1 clear_err = 1'b1;
    @(posedge clk); #1 clear_err = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'd0);

    // Full FIFO, last byte coincides with a pop.
    send_byte(8'hA1);
    send_byte(8'hA2);
    send_byte(8'hA3);
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_data  = 8'hA4;
    m_ready  = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    m_ready  = 1'b0;
    exp_q.push_back(32'hA4A3A2A1);
    check("full_pop_count", 32'(fifo_count), 32'd8);
    check("full_pop_ovf", 32'(overflow), 32'd0);
    drain("full");

    // Reset mid-operation discards FIFO contents and the partial word.
    send_word(32'h99887766, 1'b0);
    send_byte(8'h5A);
    send_byte(8'hA5);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("midrst_count", 32'(fifo_count), 32'd0);
    check("midrst_m_valid", 32'(m_valid), 32'd0);
    send_word(32'hEFBEADDE, 1'b1);
    drain("midrst");

    // Partial-word idle behaviour.
    send_byte(8'h77);
    repeat (4100) @(posedge clk);
    #1;
`ifdef UART_PACKER_TIMEOUT_EN
    check("tmo_flag", 32'(timeout_err), 32'd1);
    check("tmo_count", 32'(fifo_count), 32'd0);
    send_word(32'h0D0C0B0A, 1'b1);
    drain("tmo");
    @(posedge clk); #1 clear_err = 1'b1;
    @(posedge clk); #1 clear_err = 1'b0;
    check("tmo_cleared", 32'(timeout_err), 32'd0);
`else
    check("tmo_flag", 32'(timeout_err), 32'd0);
    check("tmo_count", 32'(fifo_count), 32'd0);
    send_byte(8'h0B);
    send_byte(8'h0C);
    send_byte(8'h0D);
    exp_q.push_back(32'h0D0C0B77);
    drain("tmo");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
